// File: rtl/text_term_writer.sv
// ============================================================================
// Module  : text_term_writer
// Brief   : Terminal-style writer for a text-mode character buffer with cursor
//           tracking, control-character handling and row/screen clearing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module text_term_writer #(
    parameter int          COLS   = 70,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  FILL   = 8'h00
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic [7:0]        data,
    output logic              wren,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] c_cols      = ADDR_W'(COLS);
    localparam logic [6:0]        c_last_col  = 7'(COLS - 1);
    localparam logic [4:0]        c_last_row  = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLR_ROW = 2'd1,
        S_CLR_ALL = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] r_clr_end;
    logic [6:0]        r_cur_x;
    logic [4:0]        r_cur_y;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_wren;
    logic [ADDR_W-1:0] r_wraddress;
    logic [7:0]        r_data;

    logic              w_accept;
    logic [4:0]        w_line_y;
    logic [ADDR_W-1:0] w_line_base;
    logic [ADDR_W-1:0] w_cur_addr;

    assign w_accept    = in_valid && r_in_ready;
    assign w_line_y    = (r_cur_y == c_last_row) ? 5'd0 : r_cur_y + 5'd1;
    assign w_line_base = ADDR_W'(w_line_y) * c_cols;
    assign w_cur_addr  = ADDR_W'(r_cur_y) * c_cols + ADDR_W'(r_cur_x);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state     <= S_CLR_ALL;
            r_clr_addr  <= '0;
            r_clr_end   <= c_last_addr;
            r_cur_x     <= 7'd0;
            r_cur_y     <= 5'd0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_wren      <= 1'b0;
            r_wraddress <= '0;
            r_data      <= FILL;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                            r_wren      <= 1'b1;
                            r_wraddress <= w_cur_addr;
                            r_data      <= in_char;
                            if (r_cur_x == c_last_col) begin
                                r_cur_x    <= 7'd0;
                                r_cur_y    <= w_line_y;
                                r_state    <= S_CLR_ROW;
                                r_clr_addr <= w_line_base;
                                r_clr_end  <= w_line_base + c_cols - 1'b1;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b1;
                            end else begin
                                r_cur_x <= r_cur_x + 7'd1;
                            end
                        end else begin
                            case (in_char)
                                8'h0A: begin
                                    r_cur_x    <= 7'd0;
                                    r_cur_y    <= w_line_y;
                                    r_state    <= S_CLR_ROW;
                                    r_clr_addr <= w_line_base;
                                    r_clr_end  <= w_line_base + c_cols - 1'b1;
                                    r_in_ready <= 1'b0;
                                    r_busy     <= 1'b1;
                                end
                                8'h0D: r_cur_x <= 7'd0;
                                8'h08: begin
                                    // Stepping back across a row boundary is still linear address - 1.
                                    if (r_cur_x != 7'd0 || r_cur_y != 5'd0) begin
                                        r_wren      <= 1'b1;
                                        r_wraddress <= w_cur_addr - 1'b1;
                                        r_data      <= FILL;
                                        if (r_cur_x != 7'd0) begin
                                            r_cur_x <= r_cur_x - 7'd1;
                                        end else begin
                                            r_cur_x <= c_last_col;
                                            r_cur_y <= r_cur_y - 5'd1;
                                        end
                                    end
                                end
                                8'h0C: begin
                                    r_cur_x    <= 7'd0;
                                    r_cur_y    <= 5'd0;
                                    r_state    <= S_CLR_ALL;
                                    r_clr_addr <= '0;
                                    r_clr_end  <= c_last_addr;
                                    r_in_ready <= 1'b0;
                                    r_busy     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_CLR_ROW, S_CLR_ALL: begin
                    r_wren      <= 1'b1;
                    r_wraddress <= r_clr_addr;
                    r_data      <= FILL;
                    if (r_clr_addr == r_clr_end) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_CLR_ALL;
                    r_clr_addr <= '0;
                    r_clr_end  <= c_last_addr;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign wren      = r_wren;
    assign wraddress = r_wraddress;
    assign data      = r_data;
    assign cursor_x  = r_cur_x;
    assign cursor_y  = r_cur_y;

endmodule

`default_nettype wire
